multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore control FSM for a small multicycle processor. Sequences each
//   instruction through FETCH / DECODE / EXEC / [MEM] / [WB], drives the
//   datapath strobes and selects, supervises data-memory waits with a
//   16-cycle timeout, and counts retired instructions.
//
// Ports
//   CLK            in   rising-edge clock
//   RST_N          in   synchronous active-low reset
//   START          in   leave IDLE / HALTED (ignored in every other state)
//   OPCODE[3:0]    in   instruction opcode, sampled in DECODE only
//   MEM_READY      in   data-memory acknowledge, sampled in MEM only
//   IR_WRITE       out  load instruction register
//   PC_WRITE       out  load PC unconditionally
//   PC_WRITE_COND  out  load PC if ALU result is zero
//   ALU_OP[1:0]    out  00 add, 01 sub, 10 and
//   ALU_SRC_B[1:0] out  00 register B, 01 constant 1, 10 immediate
//   REG_WRITE      out  register-file write enable
//   REG_DST        out  destination register select (1 = rd field)
//   MEM_READ       out  data-memory read strobe
//   MEM_WRITE      out  data-memory write strobe
//   MEM_TO_REG     out  write-back data from memory
//   HALT           out  processor halted
//   ERR            out  halt was caused by an error
//   STATE[2:0]     out  current state code
//   INSTR_COUNT    out  retired-instruction count (wraps silently)
module multicycle_ctrl #(
    // Value loaded into INSTR_COUNT by reset.
    parameter logic [15:0] INSTR_COUNT_RESET = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [3:0]  OPCODE,
    input  logic        MEM_READY,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic        PC_WRITE_COND,
    output logic [1:0]  ALU_OP,
    output logic [1:0]  ALU_SRC_B,
    output logic        REG_WRITE,
    output logic        REG_DST,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        MEM_TO_REG,
    output logic        HALT,
    output logic        ERR,
    output logic [2:0]  STATE,
    output logic [15:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_HALT = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_REG = 2'b00,
        SRC_ONE = 2'b01,
        SRC_IMM = 2'b10
    } src_b_t;

    state_t      state, state_nx;
    logic [3:0]  opcode_q, opcode_nx;
    logic [3:0]  wait_cnt, wait_nx;
    logic        err_q, err_nx;
    logic [15:0] instr_count;
    logic        retire;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            opcode_q    <= '0;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
            instr_count <= INSTR_COUNT_RESET;
        end else begin
            state       <= state_nx;
            opcode_q    <= opcode_nx;
            wait_cnt    <= wait_nx;
            err_q       <= err_nx;
            instr_count <= instr_count + {15'd0, retire};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        opcode_nx = opcode_q;
        wait_nx   = wait_cnt;
        err_nx    = err_q;
        retire    = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nx = S_FETCH;
                end
            end

            S_FETCH: begin
                state_nx = S_DECODE;
            end

            S_DECODE: begin
                opcode_nx = OPCODE;
                if (OPCODE == OP_HALT) begin
                    state_nx = S_HALTED;
                    err_nx   = 1'b0;
                end else if (OPCODE[3]) begin
                    state_nx = S_HALTED;
                    err_nx   = 1'b1;
                end else begin
                    state_nx = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_ADD, OP_SUB, OP_AND, OP_ADDI: begin
                        state_nx = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        state_nx = S_MEM;
                        wait_nx  = '0;
                    end
                    OP_BEQ: begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_nx = S_HALTED;
                        err_nx   = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                // An acknowledge in the last permitted wait cycle still
                // completes the access, so it is tested before the timeout.
                if (MEM_READY) begin
                    case (opcode_q)
                        OP_LW: begin
                            state_nx = S_WB;
                        end
                        OP_SW: begin
                            state_nx = S_FETCH;
                            retire   = 1'b1;
                        end
                        default: begin
                            state_nx = S_HALTED;
                            err_nx   = 1'b1;
                        end
                    endcase
                end else if (wait_cnt == 4'hF) begin
                    state_nx = S_HALTED;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 4'd1;
                end
            end

            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end

            S_HALTED: begin
                if (START) begin
                    state_nx = S_FETCH;
                    err_nx   = 1'b0;
                end
            end

            default: begin
                state_nx = S_HALTED;
                err_nx   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: current state and captured opcode only
    // ------------------------------------------------------------------
    always_comb begin
        IR_WRITE      = 1'b0;
        PC_WRITE      = 1'b0;
        PC_WRITE_COND = 1'b0;
        ALU_OP        = ALU_ADD;
        ALU_SRC_B     = SRC_REG;
        REG_WRITE     = 1'b0;
        REG_DST       = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_TO_REG    = 1'b0;
        HALT          = 1'b0;

        case (state)
            S_FETCH: begin
                IR_WRITE  = 1'b1;
                PC_WRITE  = 1'b1;
                ALU_OP    = ALU_ADD;
                ALU_SRC_B = SRC_ONE;
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_ADD: begin
                        ALU_OP    = ALU_ADD;
                        ALU_SRC_B = SRC_REG;
                    end
                    OP_SUB: begin
                        ALU_OP    = ALU_SUB;
                        ALU_SRC_B = SRC_REG;
                    end
                    OP_AND: begin
                        ALU_OP    = ALU_AND;
                        ALU_SRC_B = SRC_REG;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ALU_OP    = ALU_ADD;
                        ALU_SRC_B = SRC_IMM;
                    end
                    OP_BEQ: begin
                        ALU_OP        = ALU_SUB;
                        ALU_SRC_B     = SRC_REG;
                        PC_WRITE_COND = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                MEM_READ  = (opcode_q == OP_LW);
                MEM_WRITE = (opcode_q == OP_SW);
            end

            S_WB: begin
                REG_WRITE  = 1'b1;
                REG_DST    = (opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                             (opcode_q == OP_AND);
                MEM_TO_REG = (opcode_q == OP_LW);
            end

            S_HALTED: begin
                HALT = 1'b1;
            end

            default: ;
        endcase
    end

    // err_q is only ever set on the transition into HALTED and cleared on
    // the way out, so it can drive ERR directly.
    assign ERR         = err_q;
    assign STATE       = state;
    assign INSTR_COUNT = instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed-vector bench for multicycle_ctrl. A second instance with a
//   reset count just below 0xFFFF shares the stimulus and exercises the
//   retired-instruction counter wrap.
module tb_multicycle_ctrl;

    // Control-output bus order:
    // {IR_WRITE, PC_WRITE, PC_WRITE_COND, ALU_OP[1:0], ALU_SRC_B[1:0],
    //  REG_WRITE, REG_DST, MEM_READ, MEM_WRITE, MEM_TO_REG, HALT, ERR}
    localparam logic [13:0] CTL_NONE     = 14'b0_0_0_00_00_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_FETCH    = 14'b1_1_0_00_01_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_EX_ADD   = 14'b0_0_0_00_00_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_EX_SUB   = 14'b0_0_0_01_00_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_EX_AND   = 14'b0_0_0_10_00_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_EX_IMM   = 14'b0_0_0_00_10_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_EX_BEQ   = 14'b0_0_1_01_00_0_0_0_0_0_0_0;
    localparam logic [13:0] CTL_MEM_RD   = 14'b0_0_0_00_00_0_0_1_0_0_0_0;
    localparam logic [13:0] CTL_MEM_WR   = 14'b0_0_0_00_00_0_0_0_1_0_0_0;
    localparam logic [13:0] CTL_WB_R     = 14'b0_0_0_00_00_1_1_0_0_0_0_0;
    localparam logic [13:0] CTL_WB_I     = 14'b0_0_0_00_00_1_0_0_0_0_0_0;
    localparam logic [13:0] CTL_WB_LW    = 14'b0_0_0_00_00_1_0_0_0_1_0_0;
    localparam logic [13:0] CTL_HALT     = 14'b0_0_0_00_00_0_0_0_0_0_1_0;
    localparam logic [13:0] CTL_HALT_ERR = 14'b0_0_0_00_00_0_0_0_0_0_1_1;

    logic        CLK = 1'b0;
    logic        RST_N, START, MEM_READY;
    logic [3:0]  OPCODE;

    logic        IR_WRITE, PC_WRITE, PC_WRITE_COND, REG_WRITE, REG_DST;
    logic        MEM_READ, MEM_WRITE, MEM_TO_REG, HALT, ERR;
    logic [1:0]  ALU_OP, ALU_SRC_B;
    logic [2:0]  STATE;
    logic [15:0] INSTR_COUNT;

    logic        w_ir_write, w_pc_write, w_pc_write_cond, w_reg_write, w_reg_dst;
    logic        w_mem_read, w_mem_write, w_mem_to_reg, w_halt, w_err;
    logic [1:0]  w_alu_op, w_alu_src_b;
    logic [2:0]  w_state;
    logic [15:0] w_instr_count;

    logic [13:0] ctl, w_ctl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 CLK = ~CLK;

    multicycle_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE),
        .MEM_READY(MEM_READY),
        .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND),
        .ALU_OP(ALU_OP), .ALU_SRC_B(ALU_SRC_B),
        .REG_WRITE(REG_WRITE), .REG_DST(REG_DST), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_TO_REG(MEM_TO_REG),
        .HALT(HALT), .ERR(ERR), .STATE(STATE), .INSTR_COUNT(INSTR_COUNT)
    );

    multicycle_ctrl #(.INSTR_COUNT_RESET(16'hFFFE)) dut_wrap (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE),
        .MEM_READY(MEM_READY),
        .IR_WRITE(w_ir_write), .PC_WRITE(w_pc_write), .PC_WRITE_COND(w_pc_write_cond),
        .ALU_OP(w_alu_op), .ALU_SRC_B(w_alu_src_b),
        .REG_WRITE(w_reg_write), .REG_DST(w_reg_dst), .MEM_READ(w_mem_read),
        .MEM_WRITE(w_mem_write), .MEM_TO_REG(w_mem_to_reg),
        .HALT(w_halt), .ERR(w_err), .STATE(w_state), .INSTR_COUNT(w_instr_count)
    );

    assign ctl = {IR_WRITE, PC_WRITE, PC_WRITE_COND, ALU_OP, ALU_SRC_B,
                  REG_WRITE, REG_DST, MEM_READ, MEM_WRITE, MEM_TO_REG, HALT, ERR};
    assign w_ctl = {w_ir_write, w_pc_write, w_pc_write_cond, w_alu_op, w_alu_src_b,
                    w_reg_write, w_reg_dst, w_mem_read, w_mem_write, w_mem_to_reg,
                    w_halt, w_err};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_sc(input string tag, input logic [2:0] st,
                             input logic [13:0] c);
        check({tag, ".state"}, {29'd0, STATE}, {29'd0, st});
        check({tag, ".ctl"}, {18'd0, ctl}, {18'd0, c});
    endtask

    // From FETCH: run a register/immediate ALU instruction back to FETCH.
    task automatic run_alu(input string tag, input logic [3:0] op,
                           input logic [13:0] c_ex, input logic [13:0] c_wb,
                           input logic [15:0] cnt_after);
        OPCODE = op;
        step();
        expect_sc({tag, ".dec"}, 3'd2, CTL_NONE);
        step();
        expect_sc({tag, ".exec"}, 3'd3, c_ex);
        step();
        expect_sc({tag, ".wb"}, 3'd5, c_wb);
        step();
        expect_sc({tag, ".fetch"}, 3'd1, CTL_FETCH);
        check({tag, ".count"}, {16'd0, INSTR_COUNT}, {16'd0, cnt_after});
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; OPCODE = 4'd0; MEM_READY = 1'b0;
        step();
        step();
        expect_sc("reset", 3'd0, CTL_NONE);
        check("reset.count", {16'd0, INSTR_COUNT}, 32'd0);

        RST_N = 1'b1;
        step();
        expect_sc("idle_hold", 3'd0, CTL_NONE);

        // ADD: 1,2,3,5,1
        START = 1'b1;
        step();
        expect_sc("add.fetch", 3'd1, CTL_FETCH);
        START = 1'b0;
        run_alu("add", 4'd1, CTL_EX_ADD, CTL_WB_R, 16'd1);

        // LW with three not-ready cycles
        OPCODE = 4'd5;
        step();
        step();
        expect_sc("lw.exec", 3'd3, CTL_EX_IMM);
        step();
        for (int i = 0; i < 4; i++) begin
            expect_sc($sformatf("lw.mem%0d", i), 3'd4, CTL_MEM_RD);
            MEM_READY = (i == 3);
            step();
        end
        MEM_READY = 1'b0;
        expect_sc("lw.wb", 3'd5, CTL_WB_LW);
        step();
        expect_sc("lw.fetch", 3'd1, CTL_FETCH);
        check("lw.count", {16'd0, INSTR_COUNT}, 32'd2);

        run_alu("sub", 4'd2, CTL_EX_SUB, CTL_WB_R, 16'd3);
        run_alu("and", 4'd3, CTL_EX_AND, CTL_WB_R, 16'd4);
        run_alu("addi", 4'd4, CTL_EX_IMM, CTL_WB_I, 16'd5);

        // BEQ retires straight from EXEC
        OPCODE = 4'd7;
        step();
        step();
        expect_sc("beq.exec", 3'd3, CTL_EX_BEQ);
        step();
        expect_sc("beq.fetch", 3'd1, CTL_FETCH);
        check("beq.count", {16'd0, INSTR_COUNT}, 32'd6);

        // SW, memory never ready: 16 MEM cycles then HALTED with ERR
        OPCODE = 4'd6;
        step();
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            expect_sc($sformatf("sw_to.mem%0d", i), 3'd4, CTL_MEM_WR);
            step();
        end
        expect_sc("sw_to.halted", 3'd6, CTL_HALT_ERR);
        check("sw_to.count", {16'd0, INSTR_COUNT}, 32'd6);
        MEM_READY = 1'b1;            // ignored outside MEM
        step();
        expect_sc("sw_to.hold", 3'd6, CTL_HALT_ERR);
        MEM_READY = 1'b0;
        START = 1'b1;
        step();
        expect_sc("sw_to.restart", 3'd1, CTL_FETCH);
        START = 1'b0;

        // SW acknowledged in the 16th wait cycle beats the timeout
        OPCODE = 4'd6;
        step();
        step();
        step();
        for (int i = 0; i < 15; i++) step();
        expect_sc("sw_late.mem15", 3'd4, CTL_MEM_WR);
        MEM_READY = 1'b1;
        step();
        MEM_READY = 1'b0;
        expect_sc("sw_late.fetch", 3'd1, CTL_FETCH);
        check("sw_late.count", {16'd0, INSTR_COUNT}, 32'd7);

        // HALT opcode: clean halt, START ignored mid-instruction
        OPCODE = 4'd0;
        START = 1'b1;
        step();
        START = 1'b0;
        expect_sc("halt.dec", 3'd2, CTL_NONE);
        step();
        expect_sc("halt.halted", 3'd6, CTL_HALT);
        START = 1'b1;
        step();
        START = 1'b0;
        expect_sc("halt.restart", 3'd1, CTL_FETCH);

        // Illegal opcode 9
        OPCODE = 4'd9;
        step();
        step();
        expect_sc("illegal.halted", 3'd6, CTL_HALT_ERR);
        check("illegal.count", {16'd0, INSTR_COUNT}, 32'd7);

        // Reset during a SW access, with MEM_READY high in the same cycle
        START = 1'b1;
        step();
        START = 1'b0;
        OPCODE = 4'd6;
        step();
        step();
        step();
        step();
        expect_sc("rst_mem.mem", 3'd4, CTL_MEM_WR);
        RST_N = 1'b0;
        MEM_READY = 1'b1;
        START = 1'b1;
        step();
        expect_sc("rst_mem.idle", 3'd0, CTL_NONE);
        check("rst_mem.count", {16'd0, INSTR_COUNT}, 32'd0);
        RST_N = 1'b1;
        MEM_READY = 1'b0;
        START = 1'b0;
        step();
        expect_sc("rst_mem.after", 3'd0, CTL_NONE);

        // Counter wrap on the second instance (reset value 0xFFFE)
        check("wrap.reset", {16'd0, w_instr_count}, 32'h0000_FFFE);
        START = 1'b1;
        step();
        START = 1'b0;
        OPCODE = 4'd7;
        step();
        step();
        step();
        check("wrap.cnt_ffff", {16'd0, w_instr_count}, 32'h0000_FFFF);
        check("wrap.ctl1", {18'd0, w_ctl}, {18'd0, CTL_FETCH});
        step();
        step();
        step();
        check("wrap.cnt_0000", {16'd0, w_instr_count}, 32'h0000_0000);
        check("wrap.ctl2", {18'd0, w_ctl}, {18'd0, CTL_FETCH});
        check("wrap.state", {29'd0, w_state}, 32'd1);
        check("wrap.main_cnt", {16'd0, INSTR_COUNT}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
